// File: rtl/writeback_arb_pkg.sv
// Shared definitions for the writeback arbiter.
// Holds the parameter defaults, the writeback entry payload layout, and a
// clog2 helper that never returns zero (so 1-entry selects stay 1 bit wide).
package writeback_arb_pkg;

  localparam int unsigned NUM_CH_DEF    = 4;
  localparam int unsigned ADDR_W_DEF    = 5;
  localparam int unsigned DATA_W_DEF    = 64;
  localparam int unsigned DEPTH_DEF     = 4;
  localparam bit          RR_MODE_DEF   = 1'b1;
  localparam bit          ZERO_DROP_DEF = 1'b1;

  // Writeback payload at the default widths.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

  // max(1, $clog2(n))
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/writeback_arb_fifo.sv
// Per-channel synchronous FIFO for the writeback arbiter.
// Ports:
//   clk, rst_n        clock, async active-low reset (pointers/count only)
//   flush             synchronous empty; overrides push and pop
//   push, wdata       write request (ignored when full)
//   pop               read request (ignored when empty)
//   rdata_c           head entry (combinational)
//   full_c, empty_c   occupancy flags (combinational from registered count)
module writeback_arb_fifo
  import writeback_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign rdata_c = mem[rd_ptr];

  assign push_ok = push && !full_c && !flush;
  assign pop_ok  = pop && !empty_c && !flush;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arb.sv
// Writeback arbiter: NUM_CH input channels, each buffered by a FIFO, merged
// into a single registered writeback output using round-robin or fixed
// priority arbitration.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       per-channel handshake (ready = FIFO not full)
//   in_addr/in_data         packed per-channel payload
//   wb_valid/wb_ready       output handshake
//   wb_addr/wb_data/wb_ch   output payload and source channel
//   flush                   synchronous discard of every entry
//   busy                    any FIFO non-empty or output valid (combinational)
module writeback_arb
  import writeback_arb_pkg::*;
#(
  parameter int unsigned NUM_CH    = NUM_CH_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter bit          RR_MODE   = RR_MODE_DEF,
  parameter bit          ZERO_DROP = ZERO_DROP_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*ADDR_W-1:0]     in_addr,
  input  logic [NUM_CH*DATA_W-1:0]     in_data,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [ADDR_W-1:0]            wb_addr,
  output logic [DATA_W-1:0]            wb_data,
  output logic [clog2_min1(NUM_CH)-1:0] wb_ch,
  input  logic                         flush,
  output logic                         busy
);

  localparam int unsigned CH_W  = clog2_min1(NUM_CH);
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  // Same layout as wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  entry_t            head [NUM_CH];

  logic              load_c;
  logic              grant_valid_c;
  logic [CH_W-1:0]   grant_c;
  int unsigned       base;

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   rr_ptr_n;
  logic              wb_valid_n;
  logic [ADDR_W-1:0] wb_addr_n;
  logic [DATA_W-1:0] wb_data_n;
  logic [CH_W-1:0]   wb_ch_n;

  // (b + k) mod NUM_CH for b < NUM_CH, k <= NUM_CH
  function automatic logic [CH_W-1:0] wrap_ch(input int unsigned b, input int unsigned k);
    int unsigned s;
    s = b + k;
    if (s >= NUM_CH) begin
      s = s - NUM_CH;
    end
    return CH_W'(s);
  endfunction

  // Per-channel FIFOs; zero-address entries are accepted but never stored.
  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    entry_t wdata;
    logic   drop;

    assign wdata   = '{addr: in_addr[g*ADDR_W +: ADDR_W], data: in_data[g*DATA_W +: DATA_W]};
    assign drop    = ZERO_DROP && (in_addr[g*ADDR_W +: ADDR_W] == '0);
    assign push[g] = in_valid[g] && !fifo_full[g] && !drop;

    writeback_arb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .push    (push[g]),
      .wdata   (wdata),
      .pop     (pop[g]),
      .rdata_c (head[g]),
      .full_c  (fifo_full[g]),
      .empty_c (fifo_empty[g])
    );
  end

  assign in_ready = ~fifo_full;
  assign busy     = (|(~fifo_empty)) || wb_valid;
  assign load_c   = !wb_valid || wb_ready;

  // Arbiter: first non-empty FIFO scanning upward from the start channel.
  always_comb begin
    grant_valid_c = 1'b0;
    grant_c       = '0;
    base          = RR_MODE ? 32'(rr_ptr) : 32'd0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!grant_valid_c && !fifo_empty[wrap_ch(base, k)]) begin
        grant_valid_c = 1'b1;
        grant_c       = wrap_ch(base, k);
      end
    end
  end

  // Pop only the winner, and only when the output stage takes it.
  always_comb begin
    pop = '0;
    if (load_c && grant_valid_c && !flush) begin
      pop[grant_c] = 1'b1;
    end
  end

  // Output stage and round-robin pointer next state; flush wins over a load.
  always_comb begin
    wb_valid_n = wb_valid;
    wb_addr_n  = wb_addr;
    wb_data_n  = wb_data;
    wb_ch_n    = wb_ch;
    rr_ptr_n   = rr_ptr;
    if (flush) begin
      wb_valid_n = 1'b0;
    end else if (load_c) begin
      wb_valid_n = grant_valid_c;
      if (grant_valid_c) begin
        wb_addr_n = head[grant_c].addr;
        wb_data_n = head[grant_c].data;
        wb_ch_n   = grant_c;
        rr_ptr_n  = wrap_ch(32'(grant_c), 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      wb_ch    <= '0;
      rr_ptr   <= '0;
    end else begin
      wb_valid <= wb_valid_n;
      wb_addr  <= wb_addr_n;
      wb_data  <= wb_data_n;
      wb_ch    <= wb_ch_n;
      rr_ptr   <= rr_ptr_n;
    end
  end

endmodule
